// File: rtl/calc_input_conditioner.sv
// calc_input_conditioner: synchronize and debounce the equal button, capture the operand on each accepted press
module calc_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_100M,
    input  logic       reset,
    input  logic       equal_btn,
    input  logic [3:0] num_sw,
    output logic       equal_pulse,
    output logic [3:0] num_out,
    output logic [7:0] press_count,
    output logic       busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept;
    logic          btn_m, btn_s;
    logic [3:0]    num_m, num_s;

    // two-flop synchronizers for the raw button and switches
    always_ff @(posedge clk_100M or posedge reset)
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            num_m <= 4'b0;
            num_s <= 4'b0;
        end else begin
            btn_m <= equal_btn;
            btn_s <= btn_m;
            num_m <= num_sw;
            num_s <= num_m;
        end

    // debounce FSM: a level must persist DEBOUNCE_CYCLES samples before it is accepted
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: if (btn_s) begin
                state_n = DB_PRESS;
                cnt_n   = '0;
            end
            DB_PRESS: if (!btn_s) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (cnt == LAST) begin
                state_n = HELD;
                cnt_n   = '0;
                accept  = 1'b1;
            end else cnt_n = cnt + CW'(1);
            HELD: if (!btn_s) begin
                state_n = DB_RELEASE;
                cnt_n   = '0;
            end
            DB_RELEASE: if (btn_s) begin
                state_n = HELD;
                cnt_n   = '0;
            end else if (cnt == LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else cnt_n = cnt + CW'(1);
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // state register plus registered strobe, operand capture, press counter and busy decode
    always_ff @(posedge clk_100M or posedge reset)
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            equal_pulse <= 1'b0;
            num_out     <= 4'b0;
            press_count <= 8'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            equal_pulse <= accept;
            busy        <= state_n != IDLE;
            if (accept) begin
                num_out     <= num_s;
                press_count <= press_count + 8'd1;
            end
        end
endmodule
